alu_seq_ctrl: RTL and testbench

Byte-serial multi-precision sequencer for the 8-bit combinational ALU. It accepts one NBYTES-wide operation through a valid/ready handshake. It then drives the ALU one byte per cycle, LSB first, chaining carry between bytes, and presents the assembled result and flags on a valid/ready output handshake. It sits between the core control logic and the ALU and owns the ALU's command and operand inputs while busy.

---
 rtl/alu_seq_ctrl.sv | 169 ++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// Byte-serial multi-precision sequencer driving an 8-bit combinational ALU.
// Walks operands LSB first, chaining carry, and holds the result until taken.
`timescale 1ns/1ps
module alu_seq_ctrl #(
   parameter int NBYTES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            in_op,
   input  logic [8*NBYTES-1:0]   in_a,
   input  logic [8*NBYTES-1:0]   in_b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [8*NBYTES-1:0]   out_res,
   output logic                  out_carry,
   output logic                  out_zero,
   output logic                  out_err,
   output logic [3:0]            alu_cmd,
   output logic [7:0]            alu_acc,
   output logic [7:0]            alu_op,
   output logic                  alu_cin,
   input  logic [7:0]            alu_result,
   input  logic                  alu_cout
);

   localparam int W = 8 * NBYTES;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;

   localparam logic [3:0] CMD_ADD  = 4'b1100;
   localparam logic [3:0] CMD_AND  = 4'b1000;
   localparam logic [3:0] CMD_OR   = 4'b1001;
   localparam logic [3:0] CMD_XOR  = 4'b1010;
   localparam logic [3:0] CMD_PASS = 4'b1110;
   localparam logic [3:0] CMD_BAD  = 4'b1111;

   localparam logic [2:0] LAST = 3'(NBYTES - 1);

   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

   state_t         state;
   state_t         state_nx;
   logic [W-1:0]   a_q;
   logic [W-1:0]   b_q;
   logic [W-1:0]   res_q;
   logic [W-1:0]   res_nx;
   logic [2:0]     op_q;
   logic [2:0]     idx;
   logic           carry;
   logic           zacc;
   logic           is_arith;
   logic           is_bad;
   logic           last;
   logic           byte_zero;
   logic [7:0]     a_byte;
   logic [7:0]     b_byte;

   assign a_byte    = a_q[{idx, 3'b000} +: 8];
   assign b_byte    = b_q[{idx, 3'b000} +: 8];
   assign is_arith  = (op_q == OP_ADD) || (op_q == OP_SUB);
   assign is_bad    = (op_q > OP_XOR);
   assign last      = (idx == LAST);
   assign byte_zero = (alu_result == 8'h00);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state: accept, walk NBYTES bytes, wait for consumer
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (in_valid)  state_nx = RUN;
         RUN:     if (last)      state_nx = HOLD;
         HOLD:    if (out_ready) state_nx = IDLE;
         default:                state_nx = IDLE;
      endcase
   end

   // Handshake outputs and per-byte ALU drive
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      alu_cmd   = CMD_PASS;
      alu_acc   = 8'h00;
      alu_op    = 8'h00;
      alu_cin   = 1'b0;
      unique case (state)
         IDLE: in_ready = 1'b1;
         RUN: begin
            alu_acc = a_byte;
            alu_op  = b_byte;
            case (op_q)
               OP_ADD: begin
                  alu_cmd = CMD_ADD;
                  alu_cin = carry;
               end
               OP_SUB: begin
                  alu_cmd = CMD_ADD;
                  alu_op  = ~b_byte;
                  alu_cin = carry;
               end
               OP_AND:  alu_cmd = CMD_AND;
               OP_OR:   alu_cmd = CMD_OR;
               OP_XOR:  alu_cmd = CMD_XOR;
               default: begin
                  alu_cmd = CMD_BAD;
                  alu_acc = 8'h00;
                  alu_op  = 8'h00;
               end
            endcase
         end
         HOLD:    out_valid = 1'b1;
         default: ;
      endcase
   end

   // Result with the current ALU byte merged in
   always_comb begin
      res_nx = res_q;
      res_nx[{idx, 3'b000} +: 8] = alu_result;
   end

   // Operand latch, byte accumulation and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= 3'd0;
         idx       <= 3'd0;
         carry     <= 1'b0;
         zacc      <= 1'b0;
         res_q     <= '0;
         out_res   <= '0;
         out_carry <= 1'b0;
         out_zero  <= 1'b0;
         out_err   <= 1'b0;
      end else if (state == IDLE) begin
         if (in_valid) begin
            a_q   <= in_a;
            b_q   <= in_b;
            op_q  <= in_op;
            idx   <= 3'd0;
            carry <= (in_op == OP_SUB);
            zacc  <= 1'b1;
         end
      end else if (state == RUN) begin
         res_q <= res_nx;
         carry <= is_arith & alu_cout;
         zacc  <= zacc & byte_zero;
         idx   <= idx + 3'd1;
         if (last) begin
            out_res   <= is_bad ? '0 : res_nx;
            out_carry <= ~is_bad & is_arith & alu_cout;
            out_zero  <= is_bad | (zacc & byte_zero);
            out_err   <= is_bad;
         end
      end
   end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl with a behavioural 8-bit ALU.
// Table vectors, directed corner sequences and random ops vs. a word-level model.
`timescale 1ns/1ps
module tb_alu_seq_ctrl;

   localparam int N = 2;
   localparam int W = 8 * N;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [2:0]    in_op;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_res;
   logic          out_carry;
   logic          out_zero;
   logic          out_err;
   logic [3:0]    alu_cmd;
   logic [7:0]    alu_acc;
   logic [7:0]    alu_op;
   logic          alu_cin;
   logic [7:0]    alu_result;
   logic          alu_cout;

   int checks = 0;
   int errors = 0;

   logic [3:0] seen_cmd [N];
   logic [7:0] seen_acc [N];
   logic [7:0] seen_op  [N];
   logic       seen_cin [N];

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         c;
      logic         z;
      logic         e;
   } vec_t;

   vec_t tbl [10];

   always #5 clk = ~clk;

   alu_seq_ctrl #(.NBYTES(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_a       (in_a),
      .in_b       (in_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_res    (out_res),
      .out_carry  (out_carry),
      .out_zero   (out_zero),
      .out_err    (out_err),
      .alu_cmd    (alu_cmd),
      .alu_acc    (alu_acc),
      .alu_op     (alu_op),
      .alu_cin    (alu_cin),
      .alu_result (alu_result),
      .alu_cout   (alu_cout)
   );

   // External 8-bit ALU; undefined commands return junk on purpose
   always_comb begin
      alu_result = 8'h00;
      alu_cout   = 1'b0;
      case (alu_cmd)
         4'b1100: {alu_cout, alu_result} =
                  {1'b0, alu_acc} + {1'b0, alu_op} + {8'h00, alu_cin};
         4'b1000: alu_result = alu_acc & alu_op;
         4'b1001: alu_result = alu_acc | alu_op;
         4'b1010: alu_result = alu_acc ^ alu_op;
         4'b1110: alu_result = alu_acc;
         4'b1111: begin
            alu_result = 8'h5A;
            alu_cout   = 1'b1;
         end
         default: alu_result = 8'h3C;
      endcase
   end

   function automatic void model(
      input  logic [2:0]   op,
      input  logic [W-1:0] a,
      input  logic [W-1:0] b,
      output logic [W-1:0] r,
      output logic         c,
      output logic         z,
      output logic         e
   );
      logic [W:0] s;
      r = '0;
      c = 1'b0;
      e = 1'b0;
      case (op)
         3'd0: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[W-1:0];
            c = s[W];
         end
         3'd1: begin
            r = a - b;
            c = (a >= b);
         end
         3'd2:    r = a & b;
         3'd3:    r = a | b;
         3'd4:    r = a ^ b;
         default: e = 1'b1;
      endcase
      z = (r == '0);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic request(input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b);
      int n = 0;
      while (!in_ready && n < 20) begin
         step();
         n++;
      end
      chk("req_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      step();
      in_valid = 1'b0;
      chk("busy_ready", 32'(in_ready), 32'd0);
   endtask

   task automatic run_bytes();
      for (int i = 0; i < N; i++) begin
         seen_cmd[i] = alu_cmd;
         seen_acc[i] = alu_acc;
         seen_op[i]  = alu_op;
         seen_cin[i] = alu_cin;
         chk("early_valid", 32'(out_valid), 32'd0);
         step();
      end
      chk("latency_valid", 32'(out_valid), 32'd1);
   endtask

   task automatic check_out(input string tag, input logic [2:0] op,
                            input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] r;
      logic c, z, e;
      model(op, a, b, r, c, z, e);
      chk({tag, "_res"},   32'(out_res),   32'(r));
      chk({tag, "_carry"}, 32'(out_carry), 32'(c));
      chk({tag, "_zero"},  32'(out_zero),  32'(z));
      chk({tag, "_err"},   32'(out_err),   32'(e));
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("drop_valid", 32'(out_valid), 32'd0);
      chk("idle_ready", 32'(in_ready), 32'd1);
   endtask

   task automatic full_op(input string tag, input logic [2:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b);
      request(op, a, b);
      run_bytes();
      check_out(tag, op, a, b);
      release_out();
   endtask

   initial begin
      tbl[0] = '{3'd0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{3'd1, 16'h0100, 16'h0001, 16'h00FF, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{3'd1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0};
      tbl[4] = '{3'd4, 16'hA5A5, 16'hA5A5, 16'h0000, 1'b0, 1'b1, 1'b0};
      tbl[5] = '{3'd3, 16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0, 1'b0};
      tbl[6] = '{3'd2, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 1'b0};
      tbl[7] = '{3'd6, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1, 1'b1};
      tbl[8] = '{3'd1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b1, 1'b0};
      tbl[9] = '{3'd5, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b1};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_op     = 3'd0;
      in_a      = '0;
      in_b      = '0;
      #1;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd1);
      chk("rst_res",   32'(out_res), 32'd0);
      chk("rst_err",   32'(out_err), 32'd0);
      chk("rst_cmd",   32'(alu_cmd), 32'hE);
      step();
      step();
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         request(tbl[i].op, tbl[i].a, tbl[i].b);
         run_bytes();
         chk($sformatf("tbl%0d_res", i),   32'(out_res),   32'(tbl[i].res));
         chk($sformatf("tbl%0d_carry", i), 32'(out_carry), 32'(tbl[i].c));
         chk($sformatf("tbl%0d_zero", i),  32'(out_zero),  32'(tbl[i].z));
         chk($sformatf("tbl%0d_err", i),   32'(out_err),   32'(tbl[i].e));
         release_out();
         chk($sformatf("tbl%0d_keep", i),  32'(out_res),   32'(tbl[i].res));
      end

      full_op("add_chain", 3'd0, 16'h00FF, 16'h0001);
      chk("add_cmd0", 32'(seen_cmd[0]), 32'hC);
      chk("add_cin0", 32'(seen_cin[0]), 32'd0);
      chk("add_cin1", 32'(seen_cin[1]), 32'd1);

      full_op("sub_borrow", 3'd1, 16'h0000, 16'h0001);
      chk("sub_cmd0", 32'(seen_cmd[0]), 32'hC);
      chk("sub_op0",  32'(seen_op[0]),  32'hFE);
      chk("sub_cin0", 32'(seen_cin[0]), 32'd1);

      full_op("bad_op", 3'd6, 16'h1234, 16'h5678);
      chk("bad_cmd0", 32'(seen_cmd[0]), 32'hF);
      chk("bad_cmd1", 32'(seen_cmd[1]), 32'hF);
      chk("bad_acc0", 32'(seen_acc[0]), 32'h0);
      chk("bad_op0",  32'(seen_op[0]),  32'h0);

      request(3'd0, 16'h1111, 16'h2222);
      run_bytes();
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_op    = 3'd4;
         in_a     = 16'hFFFF;
         in_b     = 16'h0000;
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_ready", 32'(in_ready), 32'd0);
         chk("bp_res",   32'(out_res), 32'h3333);
         step();
      end
      in_valid = 1'b0;
      chk("bp_res_end", 32'(out_res), 32'h3333);
      release_out();
      full_op("after_bp", 3'd1, 16'h5000, 16'h0001);

      request(3'd0, 16'h1234, 16'h4321);
      step();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", 32'(in_ready), 32'd1);
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_res",   32'(out_res), 32'd0);
      chk("mid_rst_carry", 32'(out_carry), 32'd0);
      chk("mid_rst_zero",  32'(out_zero), 32'd0);
      chk("mid_rst_err",   32'(out_err), 32'd0);
      chk("mid_rst_cmd",   32'(alu_cmd), 32'hE);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         chk("post_rst_valid", 32'(out_valid), 32'd0);
         step();
      end
      full_op("post_rst_add", 3'd0, 16'h7FFF, 16'h0001);

      for (int i = 0; i < 300; i++) begin
         logic [2:0]   op;
         logic [W-1:0] a;
         logic [W-1:0] b;
         op = 3'($urandom_range(0, 7));
         a  = W'($urandom);
         b  = W'($urandom);
         case ($urandom_range(0, 5))
            0:       b = a;
            1:       a = '1;
            2:       b = '0;
            default: ;
         endcase
         full_op($sformatf("rnd%0d", i), op, a, b);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
